// File: rtl/addsub_pkg.sv
//==============================================================================
// Module      : addsub_pkg
// Description : Shared types and elaboration helpers for the serial add/sub.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int calc_nchunk(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 1;
    endfunction

    function automatic bit params_ok(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/addsub_chunk.sv
//==============================================================================
// Module      : addsub_chunk
// Description : Combinational CHUNK-bit adder slice with carry into its MSB.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module addsub_chunk
    import addsub_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             c_msb_o
);

    logic [CHUNK:0] full_sum;

    assign full_sum = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};
    assign sum_o    = full_sum[CHUNK-1:0];
    assign cout_o   = full_sum[CHUNK];
    // The MSB sum bit is a^b^cin, so cin can be recovered from the sum.
    assign c_msb_o  = full_sum[CHUNK-1] ^ a_i[CHUNK-1] ^ b_i[CHUNK-1];

endmodule

`default_nettype wire

// File: rtl/addsub_serial_unit.sv
//==============================================================================
// Module      : addsub_serial_unit
// Description : Multi-cycle two's-complement adder/subtractor, CHUNK bits/cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module addsub_serial_unit
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    generate
        if (!params_ok(WIDTH, CHUNK)) begin : g_param_check
            $error("addsub_serial_unit: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_e           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_out_q;
    logic             overflow_q;
    logic             zero_q;

    logic [CHUNK-1:0] sum_slice;
    logic             slice_cout;
    logic             slice_cmsb;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] result_d;

    // Operands shift right so the active slice always sits at the LSBs;
    // sums enter the result from the top, landing in place after NCHUNK steps.
    addsub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_i     (a_q[CHUNK-1:0]),
        .b_i     (b_q[CHUNK-1:0]),
        .cin_i   (carry_q),
        .sum_o   (sum_slice),
        .cout_o  (slice_cout),
        .c_msb_o (slice_cmsb)
    );

    generate
        if (CHUNK == WIDTH) begin : g_single_slice
            assign a_d      = '0;
            assign b_d      = '0;
            assign result_d = sum_slice;
        end else begin : g_multi_slice
            assign a_d      = {{CHUNK{1'b0}}, a_q[WIDTH-1:CHUNK]};
            assign b_d      = {{CHUNK{1'b0}}, b_q[WIDTH-1:CHUNK]};
            assign result_d = {sum_slice, result_q[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b ^ {WIDTH{sub}};
                        carry_q    <= sub;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                BUSY: begin
                    a_q      <= a_d;
                    b_q      <= b_d;
                    result_q <= result_d;
                    carry_q  <= slice_cout;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        carry_out_q <= slice_cout;
                        overflow_q  <= slice_cout ^ slice_cmsb;
                        zero_q      <= (result_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // New operands wait for the next IDLE cycle even if offered now.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

`default_nettype wire
